// File: rtl/vdp_copper_ext.sv
// Copper coprocessor: walks a program held in a 1-cycle synchronous RAM, waits on
// raster positions and issues handshaked VDP register writes.
module vdp_copper_ext #(
    parameter int ADDR_WIDTH     = 11,
    parameter int REG_ADDR_WIDTH = 6,
    parameter int X_WIDTH        = 11,
    parameter int Y_WIDTH        = 10,
    parameter int PC_RESET       = 0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic [X_WIDTH-1:0]        raster_x,
    input  logic [Y_WIDTH-1:0]        raster_y,
    output logic [ADDR_WIDTH-1:0]     ram_read_address,
    input  logic [15:0]               ram_read_data,
    output logic [REG_ADDR_WIDTH-1:0] reg_write_address,
    output logic [15:0]               reg_write_data,
    output logic                      reg_write_en,
    input  logic                      reg_write_ready,
    output logic                      halted
);

    localparam logic [ADDR_WIDTH-1:0] PC_INIT = ADDR_WIDTH'(PC_RESET);

    localparam logic [2:0] OP_SET_X       = 3'd0;
    localparam logic [2:0] OP_WAIT_Y      = 3'd1;
    localparam logic [2:0] OP_WRITE       = 3'd2;
    localparam logic [2:0] OP_JUMP        = 3'd3;
    localparam logic [2:0] OP_WAIT_X      = 3'd4;
    localparam logic [2:0] OP_WRITE_BATCH = 3'd5;
    localparam logic [2:0] OP_WAIT_Y_GE   = 3'd6;
    localparam logic [2:0] OP_HALT        = 3'd7;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_DATA   = 3'd2,
        S_WRITE  = 3'd3,
        S_WAIT   = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t                    state_q, state_d;
    logic [ADDR_WIDTH-1:0]     pc_q, pc_d;
    logic                      data_pending_q, data_pending_d;
    logic [4:0]                remaining_q, remaining_d;
    logic [X_WIDTH-1:0]        target_x_q, target_x_d;
    logic [Y_WIDTH-1:0]        target_y_q, target_y_d;
    logic                      wait_ge_q, wait_ge_d;
    logic                      wr_en_q, wr_en_d;
    logic [REG_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [15:0]               wr_data_q, wr_data_d;

    logic [2:0]            op;
    logic [ADDR_WIDTH-1:0] pc_inc;
    logic                  wait_hit;
    logic                  at_origin;
    logic                  accept;

    assign op        = ram_read_data[15:13];
    assign pc_inc    = pc_q + ADDR_WIDTH'(1);
    assign at_origin = (raster_x == '0) && (raster_y == '0);
    assign wait_hit  = wait_ge_q ? (raster_y >= target_y_q)
                                 : ((raster_x == target_x_q) && (raster_y == target_y_q));
    // ready only counts while a request is actually outstanding
    assign accept    = (state_q == S_WRITE) && wr_en_q && reg_write_ready;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = S_FETCH;
        end else begin
            case (state_q)
                S_FETCH:  state_d = data_pending_q ? S_DATA : S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_WAIT_Y, OP_WAIT_X, OP_WAIT_Y_GE: state_d = S_WAIT;
                        OP_HALT:                            state_d = S_HALT;
                        default:                            state_d = S_FETCH;
                    endcase
                end
                S_DATA:   state_d = S_WRITE;
                S_WRITE:  if (accept)    state_d = S_FETCH;
                S_WAIT:   if (wait_hit)  state_d = S_FETCH;
                S_HALT:   if (at_origin) state_d = S_FETCH;
                default:  state_d = S_FETCH;
            endcase
        end
    end

    // Datapath and output logic
    always_comb begin
        pc_d           = pc_q;
        data_pending_d = data_pending_q;
        remaining_d    = remaining_q;
        target_x_d     = target_x_q;
        target_y_d     = target_y_q;
        wait_ge_d      = wait_ge_q;
        wr_en_d        = wr_en_q;
        wr_addr_d      = wr_addr_q;
        wr_data_d      = wr_data_q;
        if (!enable) begin
            pc_d           = PC_INIT;
            data_pending_d = 1'b0;
            wr_en_d        = 1'b0;
        end else begin
            case (state_q)
                S_DECODE: begin
                    case (op)
                        OP_SET_X: begin
                            target_x_d = ram_read_data[X_WIDTH-1:0];
                            pc_d       = pc_inc;
                        end
                        OP_WAIT_X: begin
                            target_x_d = ram_read_data[X_WIDTH-1:0];
                            wait_ge_d  = 1'b0;
                        end
                        OP_WAIT_Y: begin
                            target_y_d = ram_read_data[Y_WIDTH-1:0];
                            wait_ge_d  = 1'b0;
                        end
                        OP_WAIT_Y_GE: begin
                            target_y_d = ram_read_data[Y_WIDTH-1:0];
                            wait_ge_d  = 1'b1;
                        end
                        OP_JUMP: pc_d = ram_read_data[ADDR_WIDTH-1:0];
                        OP_WRITE: begin
                            wr_addr_d      = ram_read_data[REG_ADDR_WIDTH-1:0];
                            remaining_d    = 5'd0;
                            data_pending_d = 1'b1;
                            pc_d           = pc_inc;
                        end
                        OP_WRITE_BATCH: begin
                            wr_addr_d      = ram_read_data[REG_ADDR_WIDTH-1:0];
                            remaining_d    = ram_read_data[12:8];
                            data_pending_d = 1'b1;
                            pc_d           = pc_inc;
                        end
                        default: ;
                    endcase
                end
                S_DATA: begin
                    wr_data_d      = ram_read_data;
                    wr_en_d        = 1'b1;
                    data_pending_d = 1'b0;
                end
                S_WRITE: begin
                    if (accept) begin
                        wr_en_d = 1'b0;
                        pc_d    = pc_inc;
                        // further batch words: next word is data, register address advances
                        if (remaining_q != 5'd0) begin
                            remaining_d    = remaining_q - 5'd1;
                            wr_addr_d      = wr_addr_q + REG_ADDR_WIDTH'(1);
                            data_pending_d = 1'b1;
                        end
                    end
                end
                S_WAIT: if (wait_hit) pc_d = pc_inc;
                S_HALT: if (at_origin) pc_d = PC_INIT;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q           <= PC_INIT;
            data_pending_q <= 1'b0;
            remaining_q    <= 5'd0;
            target_x_q     <= '0;
            target_y_q     <= '0;
            wait_ge_q      <= 1'b0;
            wr_en_q        <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= 16'd0;
        end else begin
            pc_q           <= pc_d;
            data_pending_q <= data_pending_d;
            remaining_q    <= remaining_d;
            target_x_q     <= target_x_d;
            target_y_q     <= target_y_d;
            wait_ge_q      <= wait_ge_d;
            wr_en_q        <= wr_en_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
        end
    end

    assign ram_read_address  = pc_q;
    assign reg_write_address = wr_addr_q;
    assign reg_write_data    = wr_data_q;
    assign reg_write_en      = wr_en_q;
    assign halted            = (state_q == S_HALT);

endmodule
